dmux_4way: RTL and testbench

Registered 1-to-4 demultiplexer. Each clock edge, the data input `a` is routed to one of four outputs `y0`..`y3`, chosen by the 2-bit select `{sel_1, sel_0}`. All unselected outputs are driven to zero. It is a leaf datapath block used wherever one source must be steered to one of four destinations. Outputs are registered to give clean, glitch-free timing to downstream logic.

---
 rtl/dmux_4way.sv | 57 +++++
 tb/tb_dmux_4way.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dmux_4way.sv
// Registered 1-to-4 demultiplexer: a is steered to y[{sel_1,sel_0}], the other outputs are zeroed.
// Latency one clock. No backpressure: every rising edge samples a new routing decision.
module dmux_4way #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             sel_0,
  input  logic             sel_1,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);

  logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
  logic [1:0]       sel;

  assign sel = {sel_1, sel_0};

  // Full case with zero defaults, so only the selected output ever carries data.
  always_comb begin
    y0_d = '0;
    y1_d = '0;
    y2_d = '0;
    y3_d = '0;
    case (sel)
      2'b00:   y0_d = a;
      2'b01:   y1_d = a;
      2'b10:   y2_d = a;
      2'b11:   y3_d = a;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
    end
  end

  assign y0 = y0_q;
  assign y1 = y1_q;
  assign y2 = y2_q;
  assign y3 = y3_q;

endmodule

// File: tb/tb_dmux_4way.sv
// Directed bench for dmux_4way at WIDTH=1 and WIDTH=4.
module tb_dmux_4way;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       sel_0, sel_1;
  logic       y0, y1, y2, y3;
  logic [3:0] w_a;
  logic       w_sel_0, w_sel_1;
  logic [3:0] w_y0, w_y1, w_y2, w_y3;

  int n_checks = 0;
  int n_fail   = 0;

  dmux_4way #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .sel_0(sel_0), .sel_1(sel_1),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  dmux_4way #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(w_a), .sel_0(w_sel_0), .sel_1(w_sel_1),
    .y0(w_y0), .y1(w_y1), .y2(w_y2), .y3(w_y3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] v1();
    return {12'h000, y3, y2, y1, y0};
  endfunction

  function automatic logic [15:0] v4();
    return {w_y3, w_y2, w_y1, w_y0};
  endfunction

  task automatic set_sel(input logic [1:0] s);
    {sel_1, sel_0} = s;
  endtask

  initial begin
    rst_n = 1'b1;
    a = 1'b1;
    set_sel(2'b11);
    w_a = 4'h0;
    {w_sel_1, w_sel_0} = 2'b00;

    // Reset asserted before any edge, with a live input pattern.
    #1 rst_n = 1'b0;
    #1 chk("reset_async", v1(), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", v1(), 16'h0000);
    end
    chk("reset_w4", v4(), 16'h0000);
    #3 rst_n = 1'b1;
    tick();
    chk("reset_release_y3", v1(), 16'h0008);

    // Select sweep with a=1.
    a = 1'b1;
    set_sel(2'b00); tick(); chk("sweep_00", v1(), 16'h0001);
    set_sel(2'b01); tick(); chk("sweep_01", v1(), 16'h0002);
    set_sel(2'b10); tick(); chk("sweep_10", v1(), 16'h0004);
    set_sel(2'b11); tick(); chk("sweep_11", v1(), 16'h0008);

    // Data gating with a=0.
    a = 1'b0;
    set_sel(2'b00); tick(); chk("gate_00", v1(), 16'h0000);
    set_sel(2'b01); tick(); chk("gate_01", v1(), 16'h0000);
    set_sel(2'b10); tick(); chk("gate_10", v1(), 16'h0000);
    set_sel(2'b11); tick(); chk("gate_11", v1(), 16'h0000);
    a = 1'b1;
    set_sel(2'b10);
    #3 chk("gate_not_early", v1(), 16'h0000);
    tick(); chk("gate_y2", v1(), 16'h0004);

    // Mid-cycle select change takes effect only at the next edge.
    set_sel(2'b00); tick(); chk("lat_y0", v1(), 16'h0001);
    #2 set_sel(2'b11);
    #2 chk("lat_hold", v1(), 16'h0001);
    tick(); chk("lat_y3", v1(), 16'h0008);

    // Async reset pulse between edges.
    set_sel(2'b01); tick(); chk("mid_y1", v1(), 16'h0002);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset_drop", v1(), 16'h0000);
    #1 rst_n = 1'b1;
    #1 chk("mid_reset_stays", v1(), 16'h0000);
    tick(); chk("mid_reset_back", v1(), 16'h0002);

    // WIDTH=4 routing.
    w_a = 4'hA; {w_sel_1, w_sel_0} = 2'b10;
    tick(); chk("w4_y2_A", v4(), 16'h0A00);
    w_a = 4'h5; {w_sel_1, w_sel_0} = 2'b00;
    tick(); chk("w4_y0_5", v4(), 16'h0005);
    w_a = 4'hF; {w_sel_1, w_sel_0} = 2'b11;
    tick(); chk("w4_y3_F", v4(), 16'hF000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
